// File: rtl/fast_counter_bank_pkg.sv
// Shared types and carry-free mask helpers for the fast counter bank.
// Helpers operate on MAX_W-bit words; callers pass their real width and truncate.
package fast_counter_bank_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    typedef logic [MAX_W-1:0] word_t;

    // One-hot of the lowest clear bit within the low w bits; zero if all w bits are set.
    function automatic word_t ffs0(input word_t a, input int unsigned w);
        word_t oh;
        logic  found;
        oh    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (!found && (i < w) && !a[i]) begin
                oh[i] = 1'b1;
                found = 1'b1;
            end
        end
        return oh;
    endfunction

    // One-hot of the lowest set bit within the low w bits; zero if none are set.
    function automatic word_t ffs1(input word_t a, input int unsigned w);
        word_t oh;
        logic  found;
        oh    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (!found && (i < w) && a[i]) begin
                oh[i] = 1'b1;
                found = 1'b1;
            end
        end
        return oh;
    endfunction

    // Sets the one-hot bit and every bit below it.
    function automatic word_t incl_mask(input word_t oh);
        word_t m;
        logic  acc;
        m   = '0;
        acc = 1'b0;
        for (int i = int'(MAX_W) - 1; i >= 0; i--) begin
            acc  = acc | oh[i];
            m[i] = acc;
        end
        return m;
    endfunction

endpackage

// File: rtl/fast_counter_bank_incdec.sv
// Combinational INC/DEC/LOAD/CLR unit using toggle masks instead of a carry chain.
module fcb_incdec
    import fast_counter_bank_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [1:0]   op,
    input  logic [W-1:0] data,
    input  logic         sat,
    output logic [W-1:0] y,
    output logic         ov
);

    logic [W-1:0] oh0;
    logic [W-1:0] oh1;
    logic [W-1:0] inc_mask;
    logic [W-1:0] dec_mask;

    // INC flips the trailing ones plus the first zero; DEC flips trailing zeros plus the first one.
    always_comb begin
        oh0      = W'(ffs0(MAX_W'(a), W));
        oh1      = W'(ffs1(MAX_W'(a), W));
        inc_mask = W'(incl_mask(MAX_W'(oh0)));
        dec_mask = W'(incl_mask(MAX_W'(oh1)));
        y        = '0;
        ov       = 1'b0;
        case (op_t'(op))
            OP_INC: begin
                if (oh0 == '0) begin
                    ov = 1'b1;
                    y  = sat ? a : '0;
                end else begin
                    y = a ^ inc_mask;
                end
            end
            OP_DEC: begin
                if (oh1 == '0) begin
                    ov = 1'b1;
                    y  = sat ? '0 : '1;
                end else begin
                    y = a ^ dec_mask;
                end
            end
            OP_LOAD: y = data;
            OP_CLR:  y = '0;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/fast_counter_bank.sv
// Bank of N independent W-bit counters sharing one 2-stage update pipeline.
// S1 captures the request and the forwarded operand; S2 computes, writes back and responds.
module fast_counter_bank
    import fast_counter_bank_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned N   = 8,
    parameter bit          SAT = 1'b0,
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           in_vld,
    input  logic [IDW-1:0] in_id,
    input  logic [1:0]     in_op,
    input  logic [W-1:0]   in_data,
    output logic           out_vld,
    output logic [IDW-1:0] out_id,
    output logic [W-1:0]   out_val,
    output logic           out_ov,
    output logic           out_zero
);

    logic [W-1:0]   cnt_q [N];
    logic [W-1:0]   cnt_d [N];

    logic           s1_vld_q,  s1_vld_d;
    logic [IDW-1:0] s1_id_q,   s1_id_d;
    logic [1:0]     s1_op_q,   s1_op_d;
    logic [W-1:0]   s1_data_q, s1_data_d;
    logic [W-1:0]   s1_a_q,    s1_a_d;

    logic           out_vld_q,  out_vld_d;
    logic [IDW-1:0] out_id_q,   out_id_d;
    logic [W-1:0]   out_val_q,  out_val_d;
    logic           out_ov_q,   out_ov_d;
    logic           out_zero_q, out_zero_d;

    logic           in_id_ok;
    logic [IDW-1:0] in_id_eff;
    logic [W-1:0]   rd_val;
    logic [W-1:0]   s2_y;
    logic           s2_ov;

    // Channel decode: single-channel banks ignore the id, partial banks drop out-of-range ids.
    if (N == 1) begin : g_single
        assign in_id_ok  = 1'b1;
        assign in_id_eff = '0;
    end else if (N == (1 << IDW)) begin : g_pow2
        assign in_id_ok  = 1'b1;
        assign in_id_eff = in_id;
    end else begin : g_sparse
        assign in_id_ok  = (in_id < IDW'(N));
        assign in_id_eff = in_id;
    end

    fcb_incdec #(
        .W (W)
    ) u_incdec (
        .a    (s1_a_q),
        .op   (s1_op_q),
        .data (s1_data_q),
        .sat  (SAT),
        .y    (s2_y),
        .ov   (s2_ov)
    );

    always_comb begin
        s1_vld_d   = in_vld & in_id_ok;
        s1_id_d    = s1_id_q;
        s1_op_d    = s1_op_q;
        s1_data_d  = s1_data_q;
        s1_a_d     = s1_a_q;
        out_vld_d  = s1_vld_q;
        out_id_d   = out_id_q;
        out_val_d  = out_val_q;
        out_ov_d   = out_ov_q;
        out_zero_d = out_zero_q;
        rd_val     = '0;

        for (int unsigned i = 0; i < N; i++) begin
            if (in_id_eff == IDW'(i)) begin
                rd_val = cnt_q[i];
            end
        end
        // The array write from S2 lands on this same edge, so take the fresh value directly.
        if (s1_vld_q && (s1_id_q == in_id_eff)) begin
            rd_val = s2_y;
        end

        if (s1_vld_d) begin
            s1_id_d   = in_id_eff;
            s1_op_d   = in_op;
            s1_data_d = in_data;
            s1_a_d    = rd_val;
        end

        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = (s1_vld_q && (s1_id_q == IDW'(i))) ? s2_y : cnt_q[i];
        end

        if (s1_vld_q) begin
            out_id_d   = s1_id_q;
            out_val_d  = s2_y;
            out_ov_d   = s2_ov;
            out_zero_d = (s2_y == '0);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            s1_vld_q   <= 1'b0;
            s1_id_q    <= '0;
            s1_op_q    <= '0;
            s1_data_q  <= '0;
            s1_a_q     <= '0;
            out_vld_q  <= 1'b0;
            out_id_q   <= '0;
            out_val_q  <= '0;
            out_ov_q   <= 1'b0;
            out_zero_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            s1_vld_q   <= s1_vld_d;
            s1_id_q    <= s1_id_d;
            s1_op_q    <= s1_op_d;
            s1_data_q  <= s1_data_d;
            s1_a_q     <= s1_a_d;
            out_vld_q  <= out_vld_d;
            out_id_q   <= out_id_d;
            out_val_q  <= out_val_d;
            out_ov_q   <= out_ov_d;
            out_zero_q <= out_zero_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_id   = out_id_q;
    assign out_val  = out_val_q;
    assign out_ov   = out_ov_q;
    assign out_zero = out_zero_q;

endmodule

// File: tb/tb_fast_counter_bank.sv
// Directed bench for fast_counter_bank: W=8 wrap, W=8 saturate and N=6 instances.
module tb_fast_counter_bank;

    logic       clk;
    logic       arst_n;
    logic       v_vld [3];
    logic [2:0] in_id;
    logic [1:0] in_op;
    logic [7:0] in_data;

    logic       o_vld  [3];
    logic [2:0] o_id   [3];
    logic [7:0] o_val  [3];
    logic       o_ov   [3];
    logic       o_zero [3];

    int checks;
    int errors;

    typedef struct {
        int         sel;
        logic [2:0] id;
        logic [1:0] op;
        logic [7:0] data;
        logic       vld;
        logic [2:0] eid;
        logic [7:0] val;
        logic       ov;
        logic       zero;
    } vec_t;

    vec_t vq[$];

    fast_counter_bank #(.W(8), .N(8), .SAT(1'b0)) dut_wrap (
        .clk(clk), .arst_n(arst_n), .in_vld(v_vld[0]), .in_id(in_id), .in_op(in_op),
        .in_data(in_data), .out_vld(o_vld[0]), .out_id(o_id[0]), .out_val(o_val[0]),
        .out_ov(o_ov[0]), .out_zero(o_zero[0])
    );

    fast_counter_bank #(.W(8), .N(8), .SAT(1'b1)) dut_sat (
        .clk(clk), .arst_n(arst_n), .in_vld(v_vld[1]), .in_id(in_id), .in_op(in_op),
        .in_data(in_data), .out_vld(o_vld[1]), .out_id(o_id[1]), .out_val(o_val[1]),
        .out_ov(o_ov[1]), .out_zero(o_zero[1])
    );

    fast_counter_bank #(.W(8), .N(6), .SAT(1'b0)) dut_n6 (
        .clk(clk), .arst_n(arst_n), .in_vld(v_vld[2]), .in_id(in_id), .in_op(in_op),
        .in_data(in_data), .out_vld(o_vld[2]), .out_id(o_id[2]), .out_val(o_val[2]),
        .out_ov(o_ov[2]), .out_zero(o_zero[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int sel, input logic [2:0] id, input logic [1:0] op,
                       input logic [7:0] data, input logic vld, input logic [2:0] eid,
                       input logic [7:0] val, input logic ov, input logic zero);
        vec_t v;
        v.sel = sel; v.id = id; v.op = op; v.data = data;
        v.vld = vld; v.eid = eid; v.val = val; v.ov = ov; v.zero = zero;
        vq.push_back(v);
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        check($sformatf("v%0d.vld",  idx), 32'(o_vld[v.sel]),  32'(v.vld));
        check($sformatf("v%0d.id",   idx), 32'(o_id[v.sel]),   32'(v.eid));
        check($sformatf("v%0d.val",  idx), 32'(o_val[v.sel]),  32'(v.val));
        check($sformatf("v%0d.ov",   idx), 32'(o_ov[v.sel]),   32'(v.ov));
        check($sformatf("v%0d.zero", idx), 32'(o_zero[v.sel]), 32'(v.zero));
    endtask

    task automatic idle_inputs();
        for (int s = 0; s < 3; s++) v_vld[s] = 1'b0;
    endtask

    // One request per cycle; each result is checked one edge after the next request is taken.
    task automatic apply_queue();
        for (int i = 0; i <= vq.size(); i++) begin
            @(negedge clk);
            idle_inputs();
            if (i < vq.size()) begin
                v_vld[vq[i].sel] = 1'b1;
                in_id   = vq[i].id;
                in_op   = vq[i].op;
                in_data = vq[i].data;
            end
            @(posedge clk);
            #1;
            if (i > 0) check_vec(i - 1, vq[i - 1]);
        end
        vq.delete();
    endtask

    task automatic build_random();
        int         s;
        int         a;
        int         r;
        logic       ov;
        logic       inc;
        logic [2:0] id;
        for (int k = 0; k < 24; k++) begin
            s   = k % 2;
            inc = ((k / 2) % 2) == 0;
            if (k < 2)      a = 255;
            else if (k < 4) a = 0;
            else            a = int'($urandom_range(0, 255));
            id = 3'($urandom_range(0, 7));
            add(s, id, 2'b10, 8'(a), 1'b1, id, 8'(a), 1'b0, a == 0);
            if (inc) begin
                r  = a + 1;
                ov = (r > 255);
                if (ov) r = (s == 1) ? 255 : 0;
            end else begin
                ov = (a == 0);
                r  = ov ? ((s == 1) ? 0 : 255) : a - 1;
            end
            add(s, id, inc ? 2'b00 : 2'b01, 8'($urandom_range(0, 255)), 1'b1, id, 8'(r), ov, r == 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        checks  = 0;
        errors  = 0;
        arst_n  = 1'b0;
        in_id   = '0;
        in_op   = '0;
        in_data = '0;
        idle_inputs();

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst%0d.vld", s),  32'(o_vld[s]),  32'd0);
            check($sformatf("rst%0d.id", s),   32'(o_id[s]),   32'd0);
            check($sformatf("rst%0d.val", s),  32'(o_val[s]),  32'd0);
            check($sformatf("rst%0d.ov", s),   32'(o_ov[s]),   32'd0);
            check($sformatf("rst%0d.zero", s), 32'(o_zero[s]), 32'd0);
        end
        @(negedge clk);
        arst_n = 1'b1;

        // sel: 0 wrap, 1 saturate, 2 six-channel.  op: 0 INC, 1 DEC, 2 LOAD, 3 CLR
        add(0, 3'd2, 2'd2, 8'hFF, 1, 3'd2, 8'hFF, 0, 0);
        add(0, 3'd2, 2'd0, 8'h5A, 1, 3'd2, 8'h00, 1, 1);
        add(0, 3'd2, 2'd1, 8'h00, 1, 3'd2, 8'hFF, 1, 0);
        add(0, 3'd5, 2'd0, 8'hA5, 1, 3'd5, 8'h01, 0, 0);
        add(0, 3'd5, 2'd0, 8'h00, 1, 3'd5, 8'h02, 0, 0);
        add(0, 3'd5, 2'd0, 8'h00, 1, 3'd5, 8'h03, 0, 0);
        add(0, 3'd5, 2'd0, 8'h00, 1, 3'd5, 8'h04, 0, 0);
        add(0, 3'd6, 2'd0, 8'h00, 1, 3'd6, 8'h01, 0, 0);
        add(0, 3'd5, 2'd0, 8'h00, 1, 3'd5, 8'h05, 0, 0);
        add(0, 3'd6, 2'd0, 8'h00, 1, 3'd6, 8'h02, 0, 0);
        add(0, 3'd5, 2'd1, 8'h77, 1, 3'd5, 8'h04, 0, 0);
        add(0, 3'd6, 2'd0, 8'h00, 1, 3'd6, 8'h03, 0, 0);
        add(0, 3'd1, 2'd2, 8'h0F, 1, 3'd1, 8'h0F, 0, 0);
        add(0, 3'd1, 2'd0, 8'h00, 1, 3'd1, 8'h10, 0, 0);
        add(0, 3'd1, 2'd2, 8'h10, 1, 3'd1, 8'h10, 0, 0);
        add(0, 3'd1, 2'd1, 8'h00, 1, 3'd1, 8'h0F, 0, 0);
        add(0, 3'd1, 2'd3, 8'h33, 1, 3'd1, 8'h00, 0, 1);
        add(1, 3'd0, 2'd2, 8'hFF, 1, 3'd0, 8'hFF, 0, 0);
        add(1, 3'd0, 2'd0, 8'h00, 1, 3'd0, 8'hFF, 1, 0);
        add(1, 3'd0, 2'd3, 8'h00, 1, 3'd0, 8'h00, 0, 1);
        add(1, 3'd0, 2'd1, 8'h00, 1, 3'd0, 8'h00, 1, 1);
        add(1, 3'd0, 2'd0, 8'h00, 1, 3'd0, 8'h01, 0, 0);
        add(1, 3'd3, 2'd0, 8'h00, 1, 3'd3, 8'h01, 0, 0);
        add(2, 3'd0, 2'd2, 8'h10, 1, 3'd0, 8'h10, 0, 0);
        add(2, 3'd5, 2'd2, 8'h50, 1, 3'd5, 8'h50, 0, 0);
        add(2, 3'd7, 2'd0, 8'h00, 0, 3'd5, 8'h50, 0, 0);
        add(2, 3'd6, 2'd2, 8'hEE, 0, 3'd5, 8'h50, 0, 0);
        add(2, 3'd0, 2'd0, 8'h00, 1, 3'd0, 8'h11, 0, 0);
        add(2, 3'd5, 2'd0, 8'h00, 1, 3'd5, 8'h51, 0, 0);
        add(2, 3'd3, 2'd0, 8'h00, 1, 3'd3, 8'h01, 0, 0);
        apply_queue();

        build_random();
        apply_queue();

        // Reset asserted while one op sits in S1 and traffic keeps arriving.
        @(negedge clk);
        v_vld[0] = 1'b1;
        in_id    = 3'd0;
        in_op    = 2'd0;
        in_data  = 8'h00;
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check("midrst.vld", 32'(o_vld[0]), 32'd0);
        check("midrst.val", 32'(o_val[0]), 32'd0);
        @(negedge clk);
        in_id = 3'd2;
        @(posedge clk);
        #1;
        check("midrst.vld2", 32'(o_vld[0]), 32'd0);
        @(negedge clk);
        idle_inputs();
        arst_n = 1'b1;

        add(0, 3'd0, 2'd0, 8'h00, 1, 3'd0, 8'h01, 0, 0);
        add(0, 3'd2, 2'd0, 8'h00, 1, 3'd2, 8'h01, 0, 0);
        add(1, 3'd0, 2'd0, 8'h00, 1, 3'd0, 8'h01, 0, 0);
        add(2, 3'd5, 2'd0, 8'h00, 1, 3'd5, 8'h01, 0, 0);
        apply_queue();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
